// File: rtl/load_use_hazard_unit.sv
// load_use_hazard_unit: ID-stage scoreboard of in-flight loads driving stall/bubble, plus a saturating stall counter
module load_use_hazard_unit #(
    parameter int NUM_REGS       = 8,
    parameter int LOAD_LAT       = 1,
    parameter int CNT_W          = 2,
    parameter int PERF_W         = 16,
    parameter int ZERO_REG_FIXED = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        id_valid_i,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs_addr_i,
    input  logic [$clog2(NUM_REGS)-1:0] id_rt_addr_i,
    input  logic                        id_uses_rs_i,
    input  logic                        id_uses_rt_i,
    input  logic [$clog2(NUM_REGS)-1:0] id_write_addr_i,
    input  logic                        id_regwrite_i,
    input  logic                        id_memread_i,
    input  logic                        mem_busy_i,
    input  logic                        flush_i,
    output logic                        stall_o,
    output logic                        bubble_o,
    output logic [NUM_REGS-1:0]         pending_o,
    output logic [PERF_W-1:0]           stall_count_o
);
    localparam int AW = $clog2(NUM_REGS);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic hazard, issue, wr_en;

    assign hazard = id_valid_i & ~flush_i &
                    ((id_uses_rs_i & (cnt[id_rs_addr_i] != '0)) | (id_uses_rt_i & (cnt[id_rt_addr_i] != '0)));
    assign issue    = id_valid_i & ~hazard & ~flush_i;
    assign wr_en    = issue & id_regwrite_i & ~(ZERO_REG_FIXED != 0 && id_write_addr_i == '0);
    assign stall_o  = hazard;
    assign bubble_o = hazard | flush_i;

    always_comb begin
        pending_o = '0;
        for (int r = 0; r < NUM_REGS; r++) pending_o[r] = cnt[r] != '0;
    end

    // A younger write to the same register overrides the countdown: loads restart it, ALU writes clear it
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            stall_count_o <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (wr_en && id_write_addr_i == AW'(r)) cnt[r] <= id_memread_i ? CNT_W'(LOAD_LAT) : '0;
                else if (!mem_busy_i && cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
            if (hazard && !(&stall_count_o)) stall_count_o <= stall_count_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_load_use_hazard_unit.sv
// tb_load_use_hazard_unit: directed scenarios and random traffic against a tick-based readiness model
module tb_load_use_hazard_unit;
    localparam int LAT = 1;

    logic clk = 0;
    logic rstn, v, urs, urt, rw, mr, busy, fl;
    logic [2:0] rs, rt, wa;
    logic stall, bubble, stall2, bubble2;
    logic [7:0] pend, pend2;
    logic [15:0] cnt16;
    logic [2:0] cnt3;

    int errors = 0, checks = 0;
    int tick = 0;
    int ready [8];
    int sc16 = 0, sc3 = 0;

    always #5 clk = ~clk;

    load_use_hazard_unit dut (
        .clk_i(clk), .rst_n_i(rstn), .id_valid_i(v), .id_rs_addr_i(rs), .id_rt_addr_i(rt),
        .id_uses_rs_i(urs), .id_uses_rt_i(urt), .id_write_addr_i(wa), .id_regwrite_i(rw),
        .id_memread_i(mr), .mem_busy_i(busy), .flush_i(fl), .stall_o(stall), .bubble_o(bubble),
        .pending_o(pend), .stall_count_o(cnt16)
    );

    load_use_hazard_unit #(.PERF_W(3)) dut_small (
        .clk_i(clk), .rst_n_i(rstn), .id_valid_i(v), .id_rs_addr_i(rs), .id_rt_addr_i(rt),
        .id_uses_rs_i(urs), .id_uses_rt_i(urt), .id_write_addr_i(wa), .id_regwrite_i(rw),
        .id_memread_i(mr), .mem_busy_i(busy), .flush_i(fl), .stall_o(stall2), .bubble_o(bubble2),
        .pending_o(pend2), .stall_count_o(cnt3)
    );

    // A register is pending until LAT memory-advancing edges have passed since its load issued
    function automatic logic m_pend(input int r);
        return tick < ready[r];
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] m = '0;
        for (int r = 0; r < 8; r++) m[r] = m_pend(r);
        return m;
    endfunction

    function automatic logic m_haz();
        return v && !fl && ((urs && m_pend(int'(rs))) || (urt && m_pend(int'(rt))));
    endfunction

    task automatic drive(input logic v_, input logic [2:0] rs_, input logic urs_, input logic [2:0] rt_,
                         input logic urt_, input logic [2:0] wa_, input logic rw_, input logic mr_,
                         input logic busy_, input logic fl_, input logic rstn_);
        @(negedge clk);
        v = v_; rs = rs_; urs = urs_; rt = rt_; urt = urt_; wa = wa_; rw = rw_; mr = mr_;
        busy = busy_; fl = fl_; rstn = rstn_;
        #1;
    endtask

    task automatic clock_edge();
        logic haz, iss;
        int nt;
        @(posedge clk);
        haz = m_haz();
        iss = v && !haz && !fl;
        if (!rstn) begin
            for (int r = 0; r < 8; r++) ready[r] = tick;
            sc16 = 0; sc3 = 0;
        end else begin
            nt = tick + (busy ? 0 : 1);
            if (iss && rw && wa != 0) ready[wa] = mr ? nt + LAT : nt;
            if (haz) begin
                sc16 = sc16 < 65535 ? sc16 + 1 : 65535;
                sc3 = sc3 < 7 ? sc3 + 1 : 7;
            end
            tick = nt;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clock_edge();
    endtask

    task automatic load(input logic [2:0] r, input logic b);
        drive(1, 0, 0, 0, 0, r, 1, 1, b, 0, 1);
        clock_edge();
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({stall, bubble, pend, cnt16} !== 26'd0) begin
            errors++; $display("FAIL reset_state: got s=%b b=%b p=%h c=%h want all zero", stall, bubble, pend, cnt16);
        end
        load(3'd1, 0);
        load(3'd4, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (pend !== 8'h12) begin errors++; $display("FAIL preload_pending: got %h want 12", pend); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clock_edge();
        drive(1, 3'd1, 1, 3'd4, 1, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({stall, pend, cnt16} !== 25'd0) begin
            errors++; $display("FAIL reset_midop: got s=%b p=%h c=%h want 0 0 0", stall, pend, cnt16);
        end
        clock_edge();
    endtask

    task automatic test_load_use();
        do_reset();
        load(3'd3, 0);
        drive(1, 3'd3, 1, 0, 0, 3'd6, 1, 0, 0, 0, 1);
        checks++;
        if ({stall, bubble, pend} !== {2'b11, 8'h08}) begin
            errors++; $display("FAIL load_use_stall: got s=%b b=%b p=%h want 1 1 08", stall, bubble, pend);
        end
        clock_edge();
        drive(1, 3'd3, 1, 0, 0, 3'd6, 1, 0, 0, 0, 1);
        checks++;
        if ({stall, bubble, pend, cnt16} !== {2'b00, 8'h00, 16'd1}) begin
            errors++; $display("FAIL load_use_issue: got s=%b b=%b p=%h c=%0d want 0 0 00 1", stall, bubble, pend, cnt16);
        end
        clock_edge();
    endtask

    task automatic test_independent();
        do_reset();
        load(3'd3, 0);
        drive(1, 3'd1, 1, 3'd2, 1, 3'd7, 1, 0, 0, 0, 1);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL indep_gap: got stall=%b want 0", stall); end
        clock_edge();
        drive(1, 3'd0, 0, 3'd3, 1, 3'd6, 1, 0, 0, 0, 1);
        checks++;
        if ({stall, cnt16} !== 17'd0) begin
            errors++; $display("FAIL indep_reader: got s=%b c=%0d want 0 0", stall, cnt16);
        end
        clock_edge();
    endtask

    task automatic test_mem_busy();
        do_reset();
        load(3'd5, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd5, 1, 0, 0, 0, 0, 0, 1, 0, 1);
            checks++;
            if ({stall, pend[5]} !== 2'b11) begin
                errors++; $display("FAIL busy_hold%0d: got s=%b p5=%b want 1 1", i, stall, pend[5]);
            end
            clock_edge();
        end
        drive(1, 3'd5, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL busy_last: got stall=%b want 1", stall); end
        clock_edge();
        drive(1, 3'd5, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({stall, pend[5], cnt16} !== {2'b00, 16'd4}) begin
            errors++; $display("FAIL busy_release: got s=%b p5=%b c=%0d want 0 0 4", stall, pend[5], cnt16);
        end
        clock_edge();
    endtask

    task automatic test_zero_reg();
        do_reset();
        load(3'd0, 0);
        drive(1, 3'd0, 1, 3'd0, 1, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({stall, pend} !== 9'd0) begin
            errors++; $display("FAIL zero_reg: got s=%b p=%h want 0 00", stall, pend);
        end
        clock_edge();
    endtask

    task automatic test_flush();
        do_reset();
        load(3'd2, 1);
        drive(1, 3'd2, 1, 0, 0, 3'd4, 1, 1, 1, 1, 1);
        checks++;
        if ({stall, bubble} !== 2'b01) begin
            errors++; $display("FAIL flush_reader: got s=%b b=%b want 0 1", stall, bubble);
        end
        clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (pend !== 8'h04) begin errors++; $display("FAIL flush_noset: got p=%h want 04", pend); end
        clock_edge();
        drive(1, 0, 0, 0, 0, 3'd2, 1, 1, 0, 1, 1);
        clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (pend[2] !== 1'b0) begin errors++; $display("FAIL flush_load: got p2=%b want 0", pend[2]); end
    endtask

    task automatic test_alu_clear_and_reload();
        do_reset();
        load(3'd6, 1);
        drive(1, 0, 0, 0, 0, 3'd6, 1, 0, 1, 0, 1);
        clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (pend !== 8'h00) begin errors++; $display("FAIL alu_clear: got p=%h want 00", pend); end
        load(3'd7, 0);
        load(3'd7, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (pend !== 8'h80) begin errors++; $display("FAIL reload: got p=%h want 80", pend); end
        clock_edge();
    endtask

    task automatic test_saturation();
        do_reset();
        load(3'd6, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 3'd6, 1, 0, 0, 0, 1, 0, 1);
            clock_edge();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({cnt3, cnt16} !== {3'd7, 16'd10}) begin
            errors++; $display("FAIL saturate: got small=%0d wide=%0d want 7 10", cnt3, cnt16);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
                  1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 49) != 0);
            if (rstn) begin
                checks++;
                if ({stall, bubble, pend, cnt16, cnt3} !== {m_haz(), m_haz() | fl, m_mask(), 16'(sc16), 3'(sc3)}) begin
                    errors++;
                    $display("FAIL random%0d: got s=%b b=%b p=%h c=%0d c3=%0d want s=%b b=%b p=%h c=%0d c3=%0d",
                             i, stall, bubble, pend, cnt16, cnt3, m_haz(), m_haz() | fl, m_mask(), sc16, sc3);
                end
            end
            clock_edge();
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) ready[r] = 0;
        test_reset();
        test_load_use();
        test_independent();
        test_mem_busy();
        test_zero_reg();
        test_flush();
        test_alu_clear_and_reload();
        test_saturation();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_use_hazard_unit.md
Name: load_use_hazard_unit

Overview:
- Producer-side companion to the EX/WB forwarding logic.
- A per-register scoreboard of in-flight load results. It sits at the ID stage.
- When an instruction in ID reads a register whose load result cannot yet be forwarded, the block freezes PC and IF/ID and injects a bubble into ID/EX.
- It also keeps a saturating stall-cycle performance counter.

Parameters:
- NUM_REGS, 8, architectural registers; addresses are 3 bits wide.
- LOAD_LAT, 1, stall cycles loaded into the scoreboard when a load issues; legal range 1..3.
- CNT_W, 2, width of each scoreboard counter; must hold LOAD_LAT.
- PERF_W, 16, width of the stall performance counter.
- ZERO_REG_FIXED, 1, when 1, register 0 is never marked pending.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- id_valid_i  in  1  ID holds a valid instruction.
- id_rs_addr_i  in  3  ID source rs.
- id_rt_addr_i  in  3  ID source rt.
- id_uses_rs_i  in  1  the instruction reads rs.
- id_uses_rt_i  in  1  the instruction reads rt.
- id_write_addr_i  in  3  ID destination register.
- id_regwrite_i  in  1  the instruction writes a register.
- id_memread_i  in  1  the instruction is a load.
- mem_busy_i  in  1  memory stage stalled; freezes all scoreboard countdowns.
- flush_i  in  1  squash the ID instruction (branch taken or redirect).
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  write NOP controls into ID/EX.
- pending_o  out  NUM_REGS  bit r = scoreboard counter r is nonzero.
- stall_count_o  out  PERF_W  saturating count of stall cycles.

Behaviour:
- State: cnt[r] (CNT_W bits) for each register, plus the perf counter. All are registered.
- Reset: when rst_n_i=0 at an edge, all cnt=0 and stall_count_o=0. Outputs are then stall_o=0, bubble_o=0 (given no flush), pending_o=0.
- Reset mid-operation discards all pending state; the next cycle has no stall.
- hazard is combinational from the current registered cnt. hazard = id_valid_i & !flush_i & ((id_uses_rs_i & cnt[rs]!=0) | (id_uses_rt_i & cnt[rt]!=0)).
- stall_o = hazard.
- bubble_o = hazard | flush_i.
- issue = id_valid_i & !hazard & !flush_i.
- Scoreboard update per edge, in priority order:
  1. Reset.
  2. If issue & id_regwrite_i & id_memread_i & !(ZERO_REG_FIXED & dest==0): cnt[dest] <= LOAD_LAT. This set wins over the decrement of the same entry.
  3. Else, if !mem_busy_i and cnt[r]!=0: cnt[r] <= cnt[r]-1.
  4. If mem_busy_i, the entry holds.
- A non-load write (id_memread_i=0) to a register clears any pending count on that register, with the same priority as a set. A younger ALU write supersedes the older load.
- A source equal to the ID instruction's own destination uses the pre-update cnt; there is no self-hazard.
- A hazard on cycle t consumes nothing. The same instruction re-evaluates on t+1.
- Latency with LOAD_LAT=1 and no mem_busy_i:
  - Load issues at edge t, so cnt=1.
  - A dependent instruction in ID on cycle t+1 stalls for exactly 1 cycle.
  - It issues on t+2 and reaches EX while the load is in WB, where the WB forwarding path serves it.
- Two consecutive loads to different registers keep independent counters.
- A reload of the same register while pending restarts the count at LOAD_LAT.
- Perf counter: increments on each edge with stall_o=1. It saturates at all-ones; there is no wrap.
- flush_i has priority over hazard: stall_o=0 and bubble_o=1. The flushed instruction never sets the scoreboard.
- id_valid_i=0: no stall and no scoreboard set; decrement continues.

Test Plan:
- Load to r3 issued, next cycle ID reads rs=3 -> stall_o=1 and bubble_o=1 for exactly 1 cycle, then issue; pending_o goes 0x08 then 0x00; stall_count_o=1.
- Load to r3, then an independent instruction, then a reader of r3 -> no stall on any cycle; stall_count_o stays 0.
- Load to r5, mem_busy_i=1 for 3 cycles while a reader of r5 waits in ID -> stall_o held for 4 cycles total; pending_o[5] stays 1 until mem_busy_i drops.
- Load to r0 with ZERO_REG_FIXED=1, then a reader of r0 -> pending_o=0x00 and no stall.
- Reader of pending r2 with flush_i=1 -> stall_o=0, bubble_o=1, no scoreboard set. Separately, a load to r2 with flush_i=1 -> pending_o[2]=0.
- Scoreboard loaded with r1, r4 pending, rst_n_i=0 for one edge -> pending_o=0x00 and stall_count_o=0 on the next cycle. Also force stall_count_o to 0xFFFF and stall once more -> value remains 0xFFFF.
